pc_fetch_unit: RTL and testbench

- Program-counter stage that owns the PC register and issues instruction fetches.
- Drives the current PC into the downstream sequential adder (BUS-wide, operand b tied to 4) and takes its sum back as the sequential next-PC.
- Selects the next PC among the sequential, branch and jump targets.
- Runs a valid/ready request / valid response handshake with instruction memory, then presents the fetched instruction to decode with stall backpressure.

---
 rtl/pc_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter and fetches instructions.
// The current PC goes to an external adder, and the sum comes back as the
// sequential next PC. The next PC is chosen from jump, branch or sequential,
// in that priority. Fetches use a valid/ready request and a valid response.
// The fetched word is handed to decode, which can hold it off with stall.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target vectors to TRAP_VECTOR and raises
// misalign_trap. When it is undefined, the target is word-aligned by
// clearing bits [1:0].
module pc_fetch_unit #(
    parameter int unsigned    BUS          = 32,
    parameter logic [BUS-1:0] RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [BUS-1:0] TRAP_VECTOR  = 32'h0000_0180
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [BUS-1:0] pc_seq,
    input  logic           branch_taken,
    input  logic [BUS-1:0] branch_target,
    input  logic           jump,
    input  logic [BUS-1:0] jump_target,
    input  logic           stall,
    input  logic           imem_req_ready,
    input  logic           imem_rsp_valid,
    input  logic [31:0]    imem_rsp_data,
    output logic [BUS-1:0] pc_out,
    output logic           imem_req_valid,
    output logic [BUS-1:0] imem_req_addr,
    output logic [31:0]    instr_out,
    output logic           instr_valid
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic           misalign_trap
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BUS-1:0] pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic           instr_valid_q, instr_valid_d;
    logic           flush_q, flush_d;
    logic           trap_q, trap_d;

    logic           redirect;
    logic [BUS-1:0] target;
    logic [BUS-1:0] redir_pc;
    logic           redir_trap;

    // Select the redirect target. Jump has priority over branch.
    // Then apply the alignment policy.
    always_comb begin
        redirect = jump | branch_taken;
        target   = jump ? jump_target : branch_target;
`ifdef PC_MISALIGN_TRAP_EN
        redir_trap = |target[1:0];
        redir_pc   = redir_trap ? TRAP_VECTOR : target;
`else
        redir_trap = 1'b0;
        redir_pc   = target & ~{{(BUS-2){1'b0}}, 2'b11};
`endif
    end

    // Next-state, next-PC and instruction-capture logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        flush_d       = flush_q;
        trap_d        = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    pc_d   = redir_pc;
                    trap_d = redir_trap;
                end
                if (imem_req_ready) begin
                    state_d = WAIT;
                    // The memory already accepted the old address.
                    // Drop that response when the PC was redirected
                    // on the same edge.
                    if (redirect) begin
                        flush_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d   = redir_pc;
                    trap_d = redir_trap;
                    // If the stale response lands on the redirect edge,
                    // drop it now. Otherwise mark it to be dropped later.
                    if (imem_rsp_valid) begin
                        flush_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        flush_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d       = imem_rsp_data;
                        instr_valid_d = 1'b1;
                        state_d       = DELIVER;
                    end
                end
            end
            DELIVER: begin
                if (!stall) begin
                    if (redirect) begin
                        pc_d   = redir_pc;
                        trap_d = redir_trap;
                    end else begin
                        pc_d = pc_seq;
                    end
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
            trap_q        <= trap_d;
        end
    end

    assign pc_out         = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = (state_q == REQ);
    assign instr_out      = instr_q;
    assign instr_valid    = instr_valid_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_trap  = trap_q;
`else
    // The trap pulse is only observable with the optional feature.
    logic unused_trap;
    assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed, table-driven bench for pc_fetch_unit.
// It also runs a hand-written free-run sequence with a one-cycle memory model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_seq;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        misalign_trap;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC   = 32'h0000_0180;
    localparam logic        MIS_TRAP = 1'b1;
`else
    localparam logic [31:0] MIS_PC   = 32'h0000_0100;
    localparam logic        MIS_TRAP = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    always #5 clk = ~clk;

    // Model of the downstream sequential adder.
    assign pc_seq = pc_out + 32'd4;

    pc_fetch_unit #(
        .BUS          (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_seq         (pc_seq),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .stall          (stall),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (misalign_trap)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rsv;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        stl;
        logic [31:0] e_pc;
        logic        e_rv;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_trap;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic rst_n, logic rdy, logic rsv, logic [31:0] rdata,
                              logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                              logic stl, logic [31:0] e_pc, logic e_rv, logic e_iv,
                              logic [31:0] e_instr, logic e_trap);
        vec_t r;
        r.rst_n = rst_n; r.rdy = rdy; r.rsv = rsv; r.rdata = rdata;
        r.br = br; r.bt = bt; r.jp = jp; r.jt = jt; r.stl = stl;
        r.e_pc = e_pc; r.e_rv = e_rv; r.e_iv = e_iv; r.e_instr = e_instr; r.e_trap = e_trap;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int unsigned req_addr[$];
    int unsigned pulse_cyc[$];
    logic [31:0] pulse_instr[$];

    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        logic        acc;
        logic [31:0] acc_addr;

        reset_n = 1'b0; branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
        jump_target = '0; stall = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        //  rst rdy rsv rdata         br bt            jp jt            st  e_pc          rv iv e_instr       trap
        v(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h0,        0, 0, 32'h0,         0); // 0 reset
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h0,        1, 0, 32'h0,         0); // 1 IDLE->REQ
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h0,        0, 0, 32'h0,         0); // 2 ->WAIT
        v(1, 0, 1, 32'h1111_0000, 0, 32'h0,     0, 32'h0,         0, 32'h0,        0, 1, 32'h1111_0000, 0); // 3 ->DELIVER
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h4,        1, 0, 32'h1111_0000, 0); // 4 accept
        for (int i = 0; i < 4; i++)
            v(1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         0, 32'h4,        1, 0, 32'h1111_0000, 0); // 5-8 not ready
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h4,        0, 0, 32'h1111_0000, 0); // 9
        v(1, 0, 1, 32'h2222_0000, 0, 32'h0,     0, 32'h0,         0, 32'h4,        0, 1, 32'h2222_0000, 0); // 10
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h8,        1, 0, 32'h2222_0000, 0); // 11
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h8,        0, 0, 32'h2222_0000, 0); // 12
        v(1, 0, 1, 32'h3333_0000, 0, 32'h0,     0, 32'h0,         0, 32'h8,        0, 1, 32'h3333_0000, 0); // 13
        v(1, 0, 0, 32'h0,         1, 32'h200,   1, 32'h100,       0, 32'h100,      1, 0, 32'h3333_0000, 0); // 14 jump beats branch
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h100,      0, 0, 32'h3333_0000, 0); // 15 ->WAIT
        v(1, 0, 0, 32'h0,         1, 32'h40,    0, 32'h0,         0, 32'h40,       0, 0, 32'h3333_0000, 0); // 16 branch in WAIT
        v(1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,     0, 32'h0,         0, 32'h40,       1, 0, 32'h3333_0000, 0); // 17 flushed
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h40,       0, 0, 32'h3333_0000, 0); // 18
        v(1, 0, 1, 32'h2008_0005, 0, 32'h0,     0, 32'h0,         0, 32'h40,       0, 1, 32'h2008_0005, 0); // 19
        for (int i = 0; i < 5; i++)
            v(1, 0, 0, 32'h0,     1, 32'h80,    0, 32'h0,         1, 32'h40,       0, 1, 32'h2008_0005, 0); // 20-24 stall
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h44,       1, 0, 32'h2008_0005, 0); // 25 accept
        v(1, 0, 0, 32'h0,         0, 32'h0,     1, 32'h102,       0, MIS_PC,       1, 0, 32'h2008_0005, MIS_TRAP); // 26 misaligned
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, MIS_PC,       0, 0, 32'h2008_0005, 0); // 27
        v(1, 0, 1, 32'h4444_0000, 0, 32'h0,     0, 32'h0,         0, MIS_PC,       0, 1, 32'h4444_0000, 0); // 28
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, MIS_PC + 4,   1, 0, 32'h4444_0000, 0); // 29
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, MIS_PC + 4,   0, 0, 32'h4444_0000, 0); // 30 ->WAIT
        v(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h0,        0, 0, 32'h0,         0); // 31 reset mid-op
        v(1, 0, 1, 32'h5555_0000, 0, 32'h0,     0, 32'h0,         0, 32'h0,        1, 0, 32'h0,         0); // 32 stale rsp ignored
        v(1, 0, 0, 32'h0,         0, 32'h0,     1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 32'h0,        0); // 33
        v(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'hFFFF_FFFC, 0, 0, 32'h0,        0); // 34
        v(1, 0, 1, 32'h6666_0000, 0, 32'h0,     0, 32'h0,         0, 32'hFFFF_FFFC, 0, 1, 32'h6666_0000, 0); // 35
        v(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,         0, 32'h0,        1, 0, 32'h6666_0000, 0); // 36 wrap

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n        = vecs[i].rst_n;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rsv;
            imem_rsp_data  = vecs[i].rdata;
            branch_taken   = vecs[i].br;
            branch_target  = vecs[i].bt;
            jump           = vecs[i].jp;
            jump_target    = vecs[i].jt;
            stall          = vecs[i].stl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d req_addr", i), imem_req_addr, vecs[i].e_pc);
            chk($sformatf("v%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
            chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_iv});
            chk($sformatf("v%0d instr_out", i), instr_out, vecs[i].e_instr);
`ifdef PC_MISALIGN_TRAP_EN
            chk($sformatf("v%0d misalign_trap", i), {31'b0, misalign_trap}, {31'b0, vecs[i].e_trap});
`endif
        end

        // Free run: memory always ready, response one cycle after acceptance.
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        imem_req_ready = 1'b1;
        pend = 1'b0;
        pend_addr = '0;
        for (int c = 1; c <= 30 && pulse_cyc.size() < 3; c++) begin
            imem_rsp_valid = pend;
            imem_rsp_data  = 32'hC000_0000 | pend_addr;
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            pend      = acc;
            pend_addr = acc_addr;
            if (acc) req_addr.push_back(acc_addr);
            if (instr_valid) begin
                pulse_cyc.push_back(c);
                pulse_instr.push_back(instr_out);
            end
        end
        imem_rsp_valid = 1'b0;
        chk("freerun pulse count", pulse_cyc.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < pulse_cyc.size()) begin
                chk($sformatf("freerun pulse%0d cycle", k), pulse_cyc[k], 3 * (k + 1));
                chk($sformatf("freerun pulse%0d instr", k), pulse_instr[k], 32'hC000_0000 | (4 * k));
            end
            if (k < req_addr.size())
                chk($sformatf("freerun fetch%0d addr", k), req_addr[k], 4 * k);
            else
                chk($sformatf("freerun fetch%0d present", k), 32'd0, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
